xadc_drp_scheduler: RTL

- Sequences XADC DRP reads across the four auxiliary channels (VAUX6, VAUX7, VAUX14, VAUX15), replacing switch-driven single-address reads.
- On each end-of-conversion trigger, it scans all enabled channels, issues one DRP read per channel, and stores each 16-bit result in a per-channel register.
- It sits between the xadc_wiz_0 DRP port and downstream consumers: the LED bar, the BCD conversion and the seven-segment display.
- Consumers read any channel at any time through a select port, with per-channel update strobes.

---
 rtl/xadc_pkg.sv | 46 ++++
 rtl/xadc_sample_bank.sv | 64 ++++++
 rtl/xadc_drp_scheduler.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/xadc_pkg.sv
// ---------------------------------------------------------------------------
// xadc_pkg
// Shared definitions for the XADC DRP read scheduler:
//   - DRP addresses of the four auxiliary channels in use (VAUX6/7/14/15)
//   - scheduler state encoding
//   - next_slot(): picks the lowest set mask bit at or above a start index
// ---------------------------------------------------------------------------
package xadc_pkg;

    localparam logic [6:0] XADC_VAUX6  = 7'h16;
    localparam logic [6:0] XADC_VAUX7  = 7'h17;
    localparam logic [6:0] XADC_VAUX14 = 7'h1E;
    localparam logic [6:0] XADC_VAUX15 = 7'h1F;

    localparam int unsigned NUM_AUX = 4;
    localparam int unsigned IDX_W   = $clog2(NUM_AUX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_NEXT  = 2'd3
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } slot_sel_t;

    // Lowest set bit of mask whose index is >= start. Scanning downwards lets
    // the last hit (the lowest index) win without a break.
    function automatic slot_sel_t next_slot(input logic [NUM_AUX-1:0] mask,
                                            input logic [IDX_W:0]     start);
        slot_sel_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = NUM_AUX - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(start))) begin
                r.found = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/xadc_sample_bank.sv
// ---------------------------------------------------------------------------
// xadc_sample_bank
// Per-channel sample storage for the DRP scheduler.
//   clk, rst        : clock, asynchronous active-high reset
//   we, idx, data   : write port; stores data into slot idx
//   rd_sel          : readout slot select
//   rd_data         : registered sample of slot rd_sel (1-cycle latency)
//   rd_valid        : registered "slot rd_sel written since reset"
//   upd_strobe      : one-hot pulse for the slot written on the last edge
// ---------------------------------------------------------------------------
module xadc_sample_bank
    import xadc_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_AUX,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] data,
    input  logic [IDX_W-1:0]  rd_sel,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [NUM_CH-1:0] upd_strobe
);

    logic [DATA_W-1:0] sample_q [NUM_CH];
    logic [NUM_CH-1:0] valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the sample array is reset on purpose; consumers may read a
            // slot before it is ever written and must see 0, not X.
            for (int i = 0; i < int'(NUM_CH); i++) begin
                sample_q[i] <= '0;
            end
            valid_q    <= '0;
            upd_strobe <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values; the later upd_strobe[idx] write overrides
            // the clear above it without creating an ordering hazard.
            upd_strobe <= '0;
            if (we) begin
                sample_q[idx]   <= data;
                valid_q[idx]    <= 1'b1;
                upd_strobe[idx] <= 1'b1;
            end

            // Bypass the write so a slot written in cycle N is readable at N+1.
            if (we && (idx == rd_sel)) begin
                rd_data  <= data;
                rd_valid <= 1'b1;
            end else begin
                rd_data  <= sample_q[rd_sel];
                rd_valid <= valid_q[rd_sel];
            end
        end
    end

endmodule

// File: rtl/xadc_drp_scheduler.sv
// ---------------------------------------------------------------------------
// xadc_drp_scheduler
// Scans the enabled XADC auxiliary channels on every end-of-conversion and
// issues one DRP read per channel, storing each result per slot.
//   CLK100MHZ, reset      : 100 MHz clock, asynchronous active-high reset
//   eoc_in                : scan trigger (coalesced into one pending rescan)
//   ch_enable             : slot enable mask, snapshotted at scan start
//   drp_den/drp_daddr     : DRP read request (den is a one-cycle pulse)
//   drp_drdy/drp_do       : DRP read response
//   rd_sel/rd_data/rd_valid : registered readout of any slot
//   upd_strobe            : one-hot pulse on the slot just written
//   busy                  : scan in progress
//   timeout_err, err_clr  : sticky drdy-timeout flag and its clear
// ---------------------------------------------------------------------------
module xadc_drp_scheduler
    import xadc_pkg::*;
#(
    parameter int unsigned          NUM_CH   = NUM_AUX,
    parameter logic [7*NUM_CH-1:0]  CH_ADDRS = {XADC_VAUX15, XADC_VAUX14,
                                                XADC_VAUX7,  XADC_VAUX6},
    parameter int unsigned          TIMEOUT  = 255
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              eoc_in,
    input  logic [NUM_CH-1:0] ch_enable,
    output logic              drp_den,
    output logic [6:0]        drp_daddr,
    input  logic              drp_drdy,
    input  logic [15:0]       drp_do,
    input  logic [IDX_W-1:0]  rd_sel,
    output logic [15:0]       rd_data,
    output logic              rd_valid,
    output logic [NUM_CH-1:0] upd_strobe,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr
);

    localparam int unsigned CNT_W = 10;

    state_t            state_q,     state_d;
    logic [IDX_W-1:0]  idx_q,       idx_d;
    logic [NUM_CH-1:0] scan_mask_q, scan_mask_d;
    logic              pending_q,   pending_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [6:0]        daddr_q,     daddr_d;
    logic              err_q,       err_d;

    logic              timeout_hit;
    logic              bank_we;
    slot_sel_t         first_sel;
    slot_sel_t         next_sel;

    // ---------------- state register ----------------
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            scan_mask_q <= '0;
            pending_q   <= 1'b0;
            cnt_q       <= '0;
            daddr_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            scan_mask_q <= scan_mask_d;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
            daddr_q     <= daddr_d;
            err_q       <= err_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        scan_mask_d = scan_mask_q;
        pending_d   = pending_q;
        cnt_d       = cnt_q;
        daddr_d     = daddr_q;
        err_d       = err_q;
        timeout_hit = 1'b0;

        first_sel = next_slot(ch_enable, '0);
        next_sel  = next_slot(scan_mask_q, {1'b0, idx_q} + 1'b1);

        case (state_q)
            ST_IDLE: begin
                if (eoc_in || pending_q) begin
                    // An empty mask still consumes the trigger.
                    pending_d = 1'b0;
                    if (first_sel.found) begin
                        scan_mask_d = ch_enable;
                        idx_d       = first_sel.idx;
                        state_d     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (drp_drdy) begin
                    state_d = ST_NEXT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        timeout_hit = 1'b1;
                        state_d     = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                if (next_sel.found) begin
                    idx_d   = next_sel.idx;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Load the address on entry to ISSUE so it is valid alongside den and
        // stays held through WAIT.
        if (state_d == ST_ISSUE) begin
            daddr_d = CH_ADDRS[7*idx_d +: 7];
        end

        // Triggers during a scan coalesce into a single pending rescan.
        if (eoc_in && (state_q != ST_IDLE)) begin
            pending_d = 1'b1;
        end

        // A timeout in the same cycle as err_clr keeps the flag set.
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (timeout_hit) begin
            err_d = 1'b1;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        drp_den = (state_q == ST_ISSUE);
        busy    = (state_q != ST_IDLE);
        bank_we = (state_q == ST_WAIT) && drp_drdy;
    end

    assign drp_daddr   = daddr_q;
    assign timeout_err = err_q;

    xadc_sample_bank #(
        .NUM_CH (NUM_CH),
        .DATA_W (16)
    ) u_bank (
        .clk        (CLK100MHZ),
        .rst        (reset),
        .we         (bank_we),
        .idx        (idx_q),
        .data       (drp_do),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .upd_strobe (upd_strobe)
    );

endmodule
